fft_frame_loader: RTL

//  Streaming-to-frame front end for the N-point FFT (fft_np) in pak_dsp.

---
 rtl/fft_frame_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - streaming-to-frame ping-pong loader in front of fft_np
//
// Collects N samples from a valid/ready stream into one of two banks and
// presents each full bank as a parallel N*DATA_WIDTH frame with valid/ready.
//
// Ports:
//   clk              clock
//   arst_n           asynchronous active-low reset
//   src_data_in      input sample (DATA_WIDTH)
//   src_valid_in     sample valid
//   src_ready_out    loader can accept a sample (registered)
//   flush_in         1-cycle pulse: zero-pad and close the partial frame
//   frame_data_out   slot k = [k*DATA_WIDTH +: DATA_WIDTH]
//   frame_valid_out  frame_data_out holds a complete frame (registered)
//   frame_ready_in   consumer takes the frame
//
// Build option: FFT_LOADER_BITREV_EN stores arrival index i in slot
// bitrev(i, log2 N); undefined stores it in slot i.

module fft_frame_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [DATA_WIDTH-1:0]   src_data_in,
  input  logic                    src_valid_in,
  output logic                    src_ready_out,
  input  logic                    flush_in,
  output logic [N*DATA_WIDTH-1:0] frame_data_out,
  output logic                    frame_valid_out,
  input  logic                    frame_ready_in
);

  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t           bank_st [2];
  logic                  wr_sel;
  logic                  rd_sel;
  logic [AW-1:0]         wr_cnt;
  logic [DATA_WIDTH-1:0] mem [2][N];

  bank_state_t   st_n [2];
  logic          wr_sel_n;
  logic          rd_sel_n;
  logic [AW-1:0] wr_cnt_n;
  logic          accept;
  logic          handshake;
  logic          last_accept;
  logic          do_flush;
  logic          close_bank;
  logic [AW:0]   fill_level;

  // Arrival index -> storage slot.
  function automatic logic [AW-1:0] slot_of(input logic [AW-1:0] idx);
`ifdef FFT_LOADER_BITREV_EN
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = idx[AW-1-b];
    return r;
`else
    return idx;
`endif
  endfunction

  always_comb begin
    accept      = src_valid_in & src_ready_out;
    handshake   = frame_valid_out & frame_ready_in;
    last_accept = accept && (wr_cnt == AW'(N-1));
    // Samples in the bank once this cycle's accept lands; flush pads from here.
    fill_level  = {1'b0, wr_cnt} + {{AW{1'b0}}, accept};
    // An Nth accept already closes the bank; a flush on an empty bank (which
    // includes the both-banks-full case, where wr_cnt is 0) does nothing.
    do_flush    = flush_in && !last_accept && (fill_level != '0);
    close_bank  = last_accept | do_flush;

    st_n[0] = bank_st[0];
    st_n[1] = bank_st[1];
    // A handshaken bank is always FULL and the write bank never is, so the
    // release and the write-side update never target the same bank.
    if (handshake) st_n[rd_sel] = EMPTY;
    if (accept && bank_st[wr_sel] == EMPTY) st_n[wr_sel] = FILLING;
    if (close_bank) st_n[wr_sel] = FULL;

    rd_sel_n = rd_sel ^ handshake;
    wr_sel_n = wr_sel ^ close_bank;
    if (close_bank)  wr_cnt_n = '0;
    else if (accept) wr_cnt_n = wr_cnt + 1'b1;
    else             wr_cnt_n = wr_cnt;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bank_st[0]      <= EMPTY;
      bank_st[1]      <= EMPTY;
      wr_sel          <= 1'b0;
      rd_sel          <= 1'b0;
      wr_cnt          <= '0;
      src_ready_out   <= 1'b0;
      frame_valid_out <= 1'b0;
    end else begin
      bank_st[0]      <= st_n[0];
      bank_st[1]      <= st_n[1];
      wr_sel          <= wr_sel_n;
      rd_sel          <= rd_sel_n;
      wr_cnt          <= wr_cnt_n;
      src_ready_out   <= (st_n[wr_sel_n] != FULL);
      frame_valid_out <= (st_n[rd_sel_n] == FULL);
    end
  end

  // Sample storage: the accepted sample and flush padding of later indices.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < N; k++)
          mem[b][k] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (accept && wr_cnt == AW'(i))
          mem[wr_sel][slot_of(AW'(i))] <= src_data_in;
        else if (do_flush && (AW+1)'(i) >= fill_level)
          mem[wr_sel][slot_of(AW'(i))] <= '0;
      end
    end
  end

  always_comb begin
    frame_data_out = '0;
    for (int k = 0; k < N; k++)
      frame_data_out[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_sel][k];
  end

endmodule
